// File: rtl/execute_stage_if.sv
// execute_stage_if: bundles the decode-side request, the forwarding inputs and
// the memory-side result of the execute stage.
//   master : the producer of instructions / consumer of results (decode + memory side)
//   slave  : the execute stage itself
// Signal names keep their i_/o_ prefixes as seen from the execute stage.
interface execute_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
);
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_flush;
  logic [DATA_WIDTH-1:0] i_rs1_data;
  logic [DATA_WIDTH-1:0] i_rs2_data;
  logic [1:0]            i_fwd_sel_a;
  logic [1:0]            i_fwd_sel_b;
  logic [DATA_WIDTH-1:0] i_fwd_mem_data;
  logic [DATA_WIDTH-1:0] i_fwd_wb_data;
  logic [DATA_WIDTH-1:0] i_imm;
  logic [PC_WIDTH-1:0]   i_pc;
  logic                  i_alu_src_sel;
  logic [3:0]            i_alu_op;
  logic                  i_mdu_en;
  logic [1:0]            i_mdu_op;
  logic                  i_branch;
  logic [2:0]            i_branch_cond;
  logic                  i_jump;
  logic                  i_ready;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_result;
  logic [DATA_WIDTH-1:0] o_store_data;
  logic                  o_zero_flag;
  logic                  o_branch_taken;
  logic [PC_WIDTH-1:0]   o_pc_target;
  logic                  o_mdu_busy;

  modport master (
    output i_valid, i_flush, i_rs1_data, i_rs2_data, i_fwd_sel_a, i_fwd_sel_b,
           i_fwd_mem_data, i_fwd_wb_data, i_imm, i_pc, i_alu_src_sel, i_alu_op,
           i_mdu_en, i_mdu_op, i_branch, i_branch_cond, i_jump, i_ready,
    input  o_ready, o_valid, o_result, o_store_data, o_zero_flag, o_branch_taken,
           o_pc_target, o_mdu_busy
  );

  modport slave (
    input  i_valid, i_flush, i_rs1_data, i_rs2_data, i_fwd_sel_a, i_fwd_sel_b,
           i_fwd_mem_data, i_fwd_wb_data, i_imm, i_pc, i_alu_src_sel, i_alu_op,
           i_mdu_en, i_mdu_op, i_branch, i_branch_cond, i_jump, i_ready,
    output o_ready, o_valid, o_result, o_store_data, o_zero_flag, o_branch_taken,
           o_pc_target, o_mdu_busy
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: RISC-V execute stage. Forwarding operand muxes, single-cycle
// ALU, branch resolution, PC target adder and an optional iterative MUL/DIV
// unit. Results sit in a registered output stage behind a valid/ready link.
// Ports:
//   i_clk   - rising-edge clock
//   i_reset - asynchronous active-high reset
//   bus     - execute_stage_if.slave: decode request, forwarding data,
//             memory-side handshake and registered results
//
// state     | meaning
// S_IDLE    | accepting instructions; ALU/branch/jump results load directly
// S_MDU_RUN | one multiply or divide step per cycle, cnt_q counts down
// S_DONE    | MDU result waits for a free output register, then back to idle
module execute_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int ENABLE_MDU = 1
) (
  input logic            i_clk,
  input logic            i_reset,
  execute_stage_if.slave bus
);
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [SHW-1:0] CNT_INIT = SHW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MDU_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] store_q, store_d;
  logic                  zero_q, zero_d;
  logic                  taken_q, taken_d;
  logic [PC_WIDTH-1:0]   target_q, target_d;
  logic                  busy_q, busy_d;
  logic [SHW-1:0]        cnt_q, cnt_d;
  logic [1:0]            mop_q, mop_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mstore_q, mstore_d;
  logic [PC_WIDTH-1:0]   mtarget_q, mtarget_d;

  logic [DATA_WIDTH-1:0] fwd_a, fwd_b, op_a, op_b;
  logic [DATA_WIDTH-1:0] sum, alu_result, ex_result, link, mdu_result;
  logic signed [DATA_WIDTH-1:0] imm_s;
  logic [PC_WIDTH-1:0]   pc_target;
  logic                  cond, ex_taken, mdu_req, accept, ready;
  logic [DATA_WIDTH:0]   mul_sum, div_shift, div_diff;
  logic                  div_ok;

  assign ready   = !i_reset && !busy_q && (!valid_q || bus.i_ready) && !bus.i_flush;
  assign accept  = bus.i_valid && ready;
  assign mdu_req = (ENABLE_MDU != 0) && bus.i_mdu_en;

  assign bus.o_ready        = ready;
  assign bus.o_valid        = valid_q;
  assign bus.o_result       = result_q;
  assign bus.o_store_data   = store_q;
  assign bus.o_zero_flag    = zero_q;
  assign bus.o_branch_taken = taken_q;
  assign bus.o_pc_target    = target_q;
  assign bus.o_mdu_busy     = busy_q;

  // Operand selection, ALU and branch resolution
  always_comb begin
    case (bus.i_fwd_sel_a)
      2'd1:    fwd_a = bus.i_fwd_mem_data;
      2'd2:    fwd_a = bus.i_fwd_wb_data;
      default: fwd_a = bus.i_rs1_data;
    endcase
    case (bus.i_fwd_sel_b)
      2'd1:    fwd_b = bus.i_fwd_mem_data;
      2'd2:    fwd_b = bus.i_fwd_wb_data;
      default: fwd_b = bus.i_rs2_data;
    endcase
    op_a = fwd_a;
    op_b = bus.i_alu_src_sel ? bus.i_imm : fwd_b;
    sum  = op_a + op_b;

    case (bus.i_alu_op)
      4'd1:    alu_result = op_a - op_b;
      4'd2:    alu_result = op_a & op_b;
      4'd3:    alu_result = op_a | op_b;
      4'd4:    alu_result = op_a ^ op_b;
      4'd5:    alu_result = op_a << op_b[SHW-1:0];
      4'd6:    alu_result = op_a >> op_b[SHW-1:0];
      4'd7:    alu_result = DATA_WIDTH'($signed(op_a) >>> op_b[SHW-1:0]);
      4'd8:    alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd9:    alu_result = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
      default: alu_result = sum;
    endcase

    // Branches compare the forwarded registers, never the immediate.
    case (bus.i_branch_cond)
      3'd0:    cond = (fwd_a == fwd_b);
      3'd1:    cond = (fwd_a != fwd_b);
      3'd4:    cond = ($signed(fwd_a) < $signed(fwd_b));
      3'd5:    cond = !($signed(fwd_a) < $signed(fwd_b));
      3'd6:    cond = (fwd_a < fwd_b);
      3'd7:    cond = !(fwd_a < fwd_b);
      default: cond = 1'b0;
    endcase

    imm_s     = bus.i_imm;
    pc_target = bus.i_pc + PC_WIDTH'(imm_s);
    link      = DATA_WIDTH'(bus.i_pc + PC_WIDTH'(4));
    ex_taken  = bus.i_jump || (bus.i_branch && cond);

    // MDU requests only reach this path when the MDU is not built; they add.
    if (bus.i_jump)        ex_result = link;
    else if (bus.i_mdu_en) ex_result = sum;
    else                   ex_result = alu_result;
  end

  // MDU datapath. hi/lo hold accumulator+multiplier for MUL and
  // remainder+quotient for DIV. A zero divisor needs no special case: every
  // trial subtract succeeds, giving all-ones quotient and remainder = dividend.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {hi_q, lo_q[DATA_WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, mcand_q});
    div_diff  = div_shift - {1'b0, mcand_q};
    case (mop_q)
      2'd0:    mdu_result = lo_q;
      2'd1:    mdu_result = hi_q;
      2'd2:    mdu_result = lo_q;
      default: mdu_result = hi_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    result_d  = result_q;
    store_d   = store_q;
    zero_d    = zero_q;
    taken_d   = taken_q;
    target_d  = target_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    mop_d     = mop_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    mstore_d  = mstore_q;
    mtarget_d = mtarget_q;

    if (valid_q && bus.i_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (mdu_req) begin
            hi_d      = '0;
            lo_d      = op_a;
            mcand_d   = op_b;
            mop_d     = bus.i_mdu_op;
            mstore_d  = fwd_b;
            mtarget_d = pc_target;
            cnt_d     = CNT_INIT;
            busy_d    = 1'b1;
            state_d   = S_MDU_RUN;
          end else begin
            valid_d  = 1'b1;
            result_d = ex_result;
            store_d  = fwd_b;
            zero_d   = (ex_result == '0);
            taken_d  = ex_taken;
            target_d = pc_target;
          end
        end
      end
      S_MDU_RUN: begin
        if (mop_q[1]) begin
          hi_d = div_ok ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
          lo_d = {lo_q[DATA_WIDTH-2:0], div_ok};
        end else begin
          hi_d = mul_sum[DATA_WIDTH:1];
          lo_d = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
        end
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (!valid_q || bus.i_ready) begin
          valid_d  = 1'b1;
          result_d = mdu_result;
          store_d  = mstore_q;
          zero_d   = (mdu_result == '0);
          taken_d  = 1'b0;
          target_d = mtarget_q;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.i_flush) begin
      valid_d = 1'b0;
      busy_d  = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      result_q  <= '0;
      store_q   <= '0;
      zero_q    <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      mop_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      mstore_q  <= '0;
      mtarget_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      store_q   <= store_d;
      zero_q    <= zero_d;
      taken_q   <= taken_d;
      target_q  <= target_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      mop_q     <= mop_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      mstore_q  <= mstore_d;
      mtarget_q <= mtarget_d;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vectors with hand-computed expectations for
// execute_stage (32-bit data and PC, MDU enabled).
module tb_execute_stage;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  execute_stage_if #(.DATA_WIDTH(32), .PC_WIDTH(32)) bus ();

  execute_stage #(.DATA_WIDTH(32), .PC_WIDTH(32), .ENABLE_MDU(1)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU table: op, a, b, expected result (issued back to back)
  logic [3:0]  tv_op  [0:8] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd2, 4'd3, 4'd4, 4'd12};
  logic [31:0] tv_a   [0:8] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd3};
  logic [31:0] tv_b   [0:8] = '{32'h21, 32'd4, 32'd4, 32'd1, 32'd1, 32'hFF00, 32'hFF00, 32'hF0F0, 32'd4};
  logic [31:0] tv_exp [0:8] = '{32'h2, 32'h0800_0000, 32'hF800_0000, 32'd1, 32'd0,
                                32'hF000, 32'hFFF0, 32'h0, 32'd7};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_valid        = 1'b0;
    bus.i_flush        = 1'b0;
    bus.i_rs1_data     = '0;
    bus.i_rs2_data     = '0;
    bus.i_fwd_sel_a    = 2'd0;
    bus.i_fwd_sel_b    = 2'd0;
    bus.i_fwd_mem_data = '0;
    bus.i_fwd_wb_data  = '0;
    bus.i_imm          = '0;
    bus.i_pc           = '0;
    bus.i_alu_src_sel  = 1'b0;
    bus.i_alu_op       = 4'd0;
    bus.i_mdu_en       = 1'b0;
    bus.i_mdu_op       = 2'd0;
    bus.i_branch       = 1'b0;
    bus.i_branch_cond  = 3'd0;
    bus.i_jump         = 1'b0;
    bus.i_ready        = 1'b1;
  endtask

  task automatic start_mdu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    clear_inputs();
    bus.i_rs1_data = a;
    bus.i_rs2_data = b;
    bus.i_mdu_en   = 1'b1;
    bus.i_mdu_op   = op;
    bus.i_valid    = 1'b1;
    tick();
    bus.i_valid  = 1'b0;
    bus.i_mdu_en = 1'b0;
  endtask

  task automatic run_mdu(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int lat;
    int ready_hi;
    lat = 0;
    ready_hi = 0;
    start_mdu(op, a, b);
    chk({tag, "_busy"}, bus.o_mdu_busy, 1);
    while (!bus.o_valid && lat < 100) begin
      if (bus.o_ready) ready_hi++;
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 33);
    chk({tag, "_res"}, bus.o_result, exp);
    chk({tag, "_rdy_low"}, ready_hi, 0);
    chk({tag, "_busy_clr"}, bus.o_mdu_busy, 0);
    tick();
  endtask

  initial begin
    int seen;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    clear_inputs();
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_result", bus.o_result, 0);
    chk("rst_store", bus.o_store_data, 0);
    chk("rst_target", bus.o_pc_target, 0);
    chk("rst_busy", bus.o_mdu_busy, 0);
    chk("rst_ready", bus.o_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", bus.o_ready, 1);
    tick();

    // ADD then SUB back to back
    bus.i_rs1_data = 32'd5;
    bus.i_rs2_data = 32'd7;
    bus.i_alu_op   = 4'd0;
    bus.i_valid    = 1'b1;
    tick();
    chk("add_res", bus.o_result, 32'd12);
    chk("add_valid", bus.o_valid, 1);
    chk("add_zero", bus.o_zero_flag, 0);
    chk("b2b_ready", bus.o_ready, 1);
    bus.i_alu_op = 4'd1;
    tick();
    chk("sub_res", bus.o_result, 32'hFFFF_FFFE);
    chk("sub_valid", bus.o_valid, 1);
    chk("sub_zero", bus.o_zero_flag, 0);

    // ALU table, one result per cycle
    for (int i = 0; i < 9; i++) begin
      bus.i_alu_op   = tv_op[i];
      bus.i_rs1_data = tv_a[i];
      bus.i_rs2_data = tv_b[i];
      tick();
      chk($sformatf("alu%0d_res", i), bus.o_result, tv_exp[i]);
      chk($sformatf("alu%0d_zero", i), bus.o_zero_flag, (tv_exp[i] == 0));
    end

    // Forwarding
    clear_inputs();
    bus.i_valid        = 1'b1;
    bus.i_fwd_sel_a    = 2'd1;
    bus.i_fwd_mem_data = 32'h10;
    bus.i_rs1_data     = 32'h99;
    bus.i_imm          = 32'd4;
    bus.i_alu_src_sel  = 1'b1;
    bus.i_fwd_sel_b    = 2'd2;
    bus.i_fwd_wb_data  = 32'hABCD;
    bus.i_rs2_data     = 32'h55;
    tick();
    chk("fwd_mem_imm", bus.o_result, 32'h14);
    chk("fwd_store_wb", bus.o_store_data, 32'hABCD);
    bus.i_fwd_sel_a   = 2'd2;
    bus.i_fwd_sel_b   = 2'd1;
    bus.i_alu_src_sel = 1'b0;
    bus.i_alu_op      = 4'd1;
    tick();
    chk("fwd_wb_mem_sub", bus.o_result, 32'hABBD);
    chk("fwd_store_mem", bus.o_store_data, 32'h10);
    bus.i_fwd_sel_a = 2'd3;
    bus.i_fwd_sel_b = 2'd3;
    bus.i_alu_op    = 4'd0;
    tick();
    chk("fwd_sel3_add", bus.o_result, 32'hEE);
    chk("fwd_sel3_store", bus.o_store_data, 32'h55);

    // Branches, target, jump
    clear_inputs();
    bus.i_valid       = 1'b1;
    bus.i_branch      = 1'b1;
    bus.i_branch_cond = 3'd4;
    bus.i_rs1_data    = 32'hFFFF_FFFF;
    bus.i_rs2_data    = 32'd1;
    bus.i_alu_src_sel = 1'b1;
    bus.i_imm         = 32'hFFFF_FFF0;
    bus.i_pc          = 32'h100;
    tick();
    chk("blt_taken", bus.o_branch_taken, 1);
    chk("blt_target", bus.o_pc_target, 32'hF0);
    chk("blt_store", bus.o_store_data, 32'd1);
    bus.i_branch_cond = 3'd6;
    tick();
    chk("bltu_taken", bus.o_branch_taken, 0);
    bus.i_branch_cond = 3'd0;
    bus.i_rs1_data    = 32'd5;
    bus.i_rs2_data    = 32'd5;
    tick();
    chk("beq_taken", bus.o_branch_taken, 1);
    bus.i_branch_cond = 3'd2;
    tick();
    chk("cond2_taken", bus.o_branch_taken, 0);
    bus.i_branch = 1'b0;
    bus.i_jump   = 1'b1;
    bus.i_alu_op = 4'd1;
    tick();
    chk("jal_link", bus.o_result, 32'h104);
    chk("jal_taken", bus.o_branch_taken, 1);
    bus.i_valid = 1'b0;
    bus.i_jump  = 1'b0;
    tick();
    chk("drain_valid", bus.o_valid, 0);

    // MDU
    run_mdu("mulhu", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mdu("mul", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    run_mdu("divu0", 2'd2, 32'd7, 32'd0, 32'hFFFF_FFFF);
    run_mdu("remu0", 2'd3, 32'd7, 32'd0, 32'd7);
    run_mdu("divu", 2'd2, 32'd100, 32'd7, 32'd14);

    // Output stall
    clear_inputs();
    bus.i_rs1_data = 32'd1;
    bus.i_rs2_data = 32'd2;
    bus.i_valid    = 1'b1;
    tick();
    chk("stall_first", bus.o_result, 32'd3);
    bus.i_ready    = 1'b0;
    bus.i_rs1_data = 32'd10;
    bus.i_rs2_data = 32'd20;
    #1;
    chk("stall_ready0", bus.o_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_res", i), bus.o_result, 32'd3);
      chk($sformatf("stall%0d_valid", i), bus.o_valid, 1);
      chk($sformatf("stall%0d_ready", i), bus.o_ready, 0);
    end
    bus.i_ready = 1'b1;
    #1;
    chk("release_ready", bus.o_ready, 1);
    tick();
    chk("release_res", bus.o_result, 32'd30);
    bus.i_valid = 1'b0;
    tick();
    chk("release_drain", bus.o_valid, 0);

    // Flush at MDU cycle 10
    start_mdu(2'd2, 32'd100, 32'd7);
    repeat (9) tick();
    bus.i_flush = 1'b1;
    #1;
    chk("flush_ready0", bus.o_ready, 0);
    tick();
    bus.i_flush = 1'b0;
    #1;
    chk("flush_valid", bus.o_valid, 0);
    chk("flush_busy", bus.o_mdu_busy, 0);
    chk("flush_ready", bus.o_ready, 1);
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.o_valid) seen++;
    end
    chk("flush_no_stale", seen, 0);
    run_mdu("remu_after_flush", 2'd3, 32'd100, 32'd7, 32'd2);

    // Async reset mid-MDU
    start_mdu(2'd0, 32'hFFFF, 32'hFFFF);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", bus.o_mdu_busy, 0);
    chk("arst_valid", bus.o_valid, 0);
    chk("arst_result", bus.o_result, 0);
    chk("arst_ready", bus.o_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.o_valid) seen++;
    end
    chk("arst_no_stale", seen, 0);
    run_mdu("mul_after_rst", 2'd0, 32'd12345, 32'd678, 32'd8369910);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
